// File: rtl/mips_pc_seq_pkg.sv
// Shared definitions for the MIPS fetch sequencer.
//   PC_ACTION_W : width of the PC action code.
//   ACT_*       : PC action codes. They must match the PC datapath's decoder.
//   seq_state_e : sequencer states.
package mips_pc_seq_pkg;

  localparam int PC_ACTION_W = 3;

  localparam logic [PC_ACTION_W-1:0] ACT_HOLD   = 3'd0;
  localparam logic [PC_ACTION_W-1:0] ACT_INC    = 3'd1;
  localparam logic [PC_ACTION_W-1:0] ACT_BRANCH = 3'd2;
  localparam logic [PC_ACTION_W-1:0] ACT_JUMP   = 3'd3;
  localparam logic [PC_ACTION_W-1:0] ACT_JUMPR  = 3'd4;
  localparam logic [PC_ACTION_W-1:0] ACT_RESET  = 3'd5;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_FETCH,
    ST_WAIT,
    ST_DRAIN,
    ST_HALTED
  } seq_state_e;

endpackage

// File: rtl/mips_pc_fetch_holdbuf.sv
// One-entry skid register for a fetched word that decode could not take.
//   clk, rst_n : clock, async active-low reset
//   load, d    : capture d and mark the entry full
//   clear      : empty the entry (wins over load)
//   full, q    : entry valid and held word
module mips_pc_fetch_holdbuf #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         full,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      q    <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      q    <= d;
    end
  end

endmodule

// File: rtl/mips_pc_fetch_sequencer.sv
// Fetch-stage controller: drives the PC action code each cycle, keeps at most
// one imem request outstanding, squashes in-flight fetches on redirect and
// parks a word in a one-entry hold buffer while decode is stalled.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   stall, halt                decode stall, stop fetching
//   redirValid, redirAction    resolved branch/jump and its PC action
//   action, flush              PC action for next edge, kill IF/ID
//   imemReqValid/imemReqReady  request handshake at the current PC
//   imemRespValid/imemRdata    read response (no back-pressure)
//   fetchValid, instrOut       word toward IF/ID
//   halted                     sequencer parked
//
// Build option MIPS_PC_FETCH_SEQ_DELAY_SLOT_EN: branch-delay-slot semantics.
// A redirect in WAIT is remembered and applied together with the response,
// which is delivered as the delay slot; flush is never raised.
module mips_pc_fetch_sequencer
  import mips_pc_seq_pkg::*;
#(
  parameter int INSTR_W  = 32,
  parameter int ACTION_W = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                halt,
  input  logic                redirValid,
  input  logic [ACTION_W-1:0] redirAction,
  output logic [ACTION_W-1:0] action,
  output logic                flush,
  output logic                imemReqValid,
  input  logic                imemReqReady,
  input  logic                imemRespValid,
  input  logic [INSTR_W-1:0]  imemRdata,
  output logic                fetchValid,
  output logic [INSTR_W-1:0]  instrOut,
  output logic                halted
);

`ifdef MIPS_PC_FETCH_SEQ_DELAY_SLOT_EN
  localparam bit SQUASH = 1'b0;
`else
  localparam bit SQUASH = 1'b1;
`endif

  seq_state_e         state_q, state_d;
  logic               deliver;
  logic               buf_full;
  logic [INSTR_W-1:0] buf_q;

`ifdef MIPS_PC_FETCH_SEQ_DELAY_SLOT_EN
  // Redirect seen in WAIT before the response; last one wins.
  logic                pend_q;
  logic [ACTION_W-1:0] pend_act_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q     <= 1'b0;
      pend_act_q <= '0;
    end else if (state_q == ST_WAIT) begin
      if (imemRespValid) begin
        pend_q <= 1'b0;
      end else if (redirValid) begin
        pend_q     <= 1'b1;
        pend_act_q <= redirAction;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_BOOT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    action       = ACTION_W'(ACT_HOLD);
    flush        = 1'b0;
    imemReqValid = 1'b0;
    deliver      = 1'b0;
    halted       = 1'b0;
    case (state_q)
      ST_BOOT: begin
        action  = ACTION_W'(ACT_RESET);
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        imemReqValid = !redirValid && !halt && !buf_full;
        if (redirValid) begin
          action = redirAction;
          flush  = SQUASH;
        end else if (halt) begin
          state_d = ST_HALTED;
        end else if (imemReqValid && imemReqReady) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
`ifdef MIPS_PC_FETCH_SEQ_DELAY_SLOT_EN
        if (imemRespValid) begin
          deliver = 1'b1;
          state_d = ST_FETCH;
          if (redirValid)  action = redirAction;
          else if (pend_q) action = pend_act_q;
          else             action = ACTION_W'(ACT_INC);
        end
`else
        if (redirValid) begin
          action  = redirAction;
          flush   = 1'b1;
          // Without the response in hand it is still in flight: drain it.
          state_d = imemRespValid ? ST_FETCH : ST_DRAIN;
        end else if (imemRespValid) begin
          deliver = 1'b1;
          action  = ACTION_W'(ACT_INC);
          state_d = ST_FETCH;
        end
`endif
      end
      ST_DRAIN: begin
        if (redirValid) begin
          action = redirAction;
          flush  = 1'b1;
        end
        if (imemRespValid) state_d = ST_FETCH;
      end
      ST_HALTED: begin
        halted = 1'b1;
        if (redirValid) begin
          action  = redirAction;
          flush   = SQUASH;
          state_d = ST_FETCH;
        end else if (!halt) begin
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  // A word is only ever delivered in WAIT, and WAIT is only entered with the
  // buffer empty, so load never meets a full entry.
  mips_pc_fetch_holdbuf #(.W(INSTR_W)) u_holdbuf (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (deliver && stall && !flush),
    .clear (flush || !stall),
    .d     (imemRdata),
    .full  (buf_full),
    .q     (buf_q)
  );

  assign fetchValid = buf_full || deliver;
  assign instrOut   = buf_full ? buf_q : (deliver ? imemRdata : '0);

endmodule

// File: doc/mips_pc_fetch_sequencer.md
Name: mips_pc_fetch_sequencer

Overview:
- Fetch-stage controller that sequences the PC datapath and the instruction-memory request/response handshake.
- Each cycle it drives the PC action code (hold/increment/branch/jump/jump-register/reset vector).
- Keeps at most one imem request outstanding and discards in-flight fetches on redirect.
- A one-entry hold buffer absorbs a response that arrives while decode is stalled.

Parameters:
- INSTR_W, 32, instruction word width.
- ACTION_W, 3, width of PC action code.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  decode/hazard stall; a fetched word is consumed only when fetchValid && !stall
- halt  in  1  stop issuing fetches after the current one completes
- redirValid  in  1  branch/jump resolved; redirect PC this cycle
- redirAction  in  ACTION_W  BRANCH, JUMP or JUMPR code accompanying redirValid
- action  out  ACTION_W  PC action, applied by the PC register at the next edge
- flush  out  1  kill younger instruction in IF/ID
- imemReqValid  out  1  fetch request at current PC
- imemReqReady  in  1  memory accepts request
- imemRespValid  in  1  read data valid (no back-pressure; must be taken)
- imemRdata  in  INSTR_W  read data
- fetchValid  out  1  instrOut valid toward IF/ID
- instrOut  out  INSTR_W  fetched instruction
- halted  out  1  sequencer parked in HALTED

Behaviour:
- Reset (async, rst_n=0): state=BOOT, buffer empty. All outputs 0 except action=RESET.
- Action codes: HOLD=0, INC=1, BRANCH=2, JUMP=3, JUMPR=4, RESET=5. Default is HOLD.
- Priority: redirect > halt > stall > normal.
- BOOT (1 cycle): action=RESET, then go to FETCH.
- FETCH:
  - imemReqValid = !redirValid && !halt && !bufFull.
  - redirValid: action=redirAction, flush=1, stay in FETCH.
  - Else halt: go to HALTED.
  - Else req && ready: go to WAIT.
- WAIT:
  - respValid && !redirValid: action=INC. Word goes to instrOut with fetchValid=1. If stall, the word is captured into the buffer. Go to FETCH.
  - redirValid && respValid: response dropped, action=redirAction, flush=1, go to FETCH.
  - redirValid && !respValid: action=redirAction, flush=1, go to DRAIN.
- DRAIN: action=HOLD unless a new redirValid arrives (then apply it and flush; last redirect wins). Next respValid is dropped; go to FETCH.
- HALTED: halted=1, no requests. redirValid applies the action, flush=1, go to FETCH (restart). Deasserting halt alone also returns to FETCH.
- Hold buffer:
  - fetchValid = bufFull || (WAIT && respValid && !redirValid).
  - instrOut comes from the buffer when bufFull.
  - Buffer clears when !stall, or on flush (flush empties the buffer the same cycle).
  - While bufFull, no new request is issued.
- Latency: request accept to fetchValid = imem latency + 0 (response bypasses to instrOut combinationally).
- Reset mid-WAIT: an outstanding response arriving after reset release is ignored, because BOOT/FETCH do not sample imemRespValid.

Optional Feature:
MIPS_PC_FETCH_SEQ_DELAY_SLOT_EN:
- Defined: MIPS branch-delay-slot semantics. A redirect in WAIT does not discard the in-flight fetch. The response is delivered as the delay slot, then the redirect action is applied in the same cycle as the response (action=redirAction instead of INC). flush is never asserted and DRAIN is unreachable. A redirect in FETCH/HALTED applies immediately without flush.
- Undefined: behaviour as above (squash with flush).

Decomposition:
- Shared package mips_pc_seq_pkg:
  - action code constants and ACTION_W;
  - state enum BOOT/FETCH/WAIT/DRAIN/HALTED.
- Action codes must match the PC datapath's action encoding.
- One natural sub-module: mips_pc_fetch_holdbuf (1-entry skid register with valid, load, clear).

Test Plan:
- Reset release, ready=1, 1-cycle latency, no stall -> action RESET, then the INC/HOLD pattern; fetchValid every 2nd cycle carrying 0x24020001, 0x24030002.
- Response arrives with stall=1 for 3 cycles -> fetchValid held 3 cycles with instrOut stable at 0x8C010004. imemReqValid=0 until stall drops. Exactly one INC issued.
- redirValid with JUMP (3) in WAIT, response 2 cycles later -> action=3, flush=1, state DRAIN. Late word not presented, then a new request issues.
- Redirect with BRANCH (2) coincident with respValid -> response dropped, action=2, flush=1. Build with DELAY_SLOT_EN: word presented, action=2, flush=0.
- halt=1 in FETCH -> halted=1 next cycle, no requests for 10 cycles. redirValid JUMPR (4) -> action=4, restart fetch.
- rst_n asserted in WAIT while a response is pending -> outputs reset asynchronously. The stale respValid after release produces no fetchValid.
